// File: rtl/demux_striping_lanes.sv
// Round-robin striping of accepted input words over NUM_LANES valid/ready output lanes,
// with a run-time lane-enable mask and a pointer realign control, all in the clk_2f domain.

module demux_lane_reg #(
    parameter int DATA_W = 32
) (
    input  logic              clk_2f,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] din,
    input  logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              vld
);
    // Load wins over pop; a pop alone drops valid but keeps the last word visible.
    always_ff @(posedge clk_2f) begin
        if (reset) begin
            dout <= '0;
            vld  <= 1'b0;
        end else if (load) begin
            dout <= din;
            vld  <= 1'b1;
        end else if (vld && ready) begin
            vld  <= 1'b0;
        end
    end
endmodule

module demux_striping_lanes #(
    parameter  int DATA_W    = 32,
    parameter  int NUM_LANES = 4,
    localparam int SEL_W     = $clog2(NUM_LANES)
) (
    input  logic                          clk_2f,
    input  logic                          reset,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          valid_in,
    output logic                          in_ready,
    input  logic [NUM_LANES-1:0]          lane_en,
    input  logic                          realign,
    output logic [NUM_LANES*DATA_W-1:0]   data_out,
    output logic [NUM_LANES-1:0]          valid_out,
    input  logic [NUM_LANES-1:0]          lane_ready,
    output logic [SEL_W-1:0]              lane_ptr,
    output logic                          err_no_lane
);
    logic [NUM_LANES-1:0][DATA_W-1:0] lane_q;
    logic [NUM_LANES-1:0]             load;
    logic [SEL_W-1:0]                 first_en;
    logic [SEL_W-1:0]                 next_en;
    logic [SEL_W-1:0]                 cand;
    logic [SEL_W-1:0]                 ptr_d;
    logic                             any_en;
    logic                             accept;
    logic                             skip;

    assign any_en      = |lane_en;
    assign err_no_lane = ~any_en;
    assign in_ready    = ~realign & lane_en[lane_ptr]
                       & (~valid_out[lane_ptr] | lane_ready[lane_ptr]);
    assign accept      = valid_in & in_ready;
    assign skip        = ~realign & any_en & ~lane_en[lane_ptr];

    always_comb begin
        first_en = '0;
        for (int i = NUM_LANES - 1; i >= 0; i--) begin
            if (lane_en[i]) first_en = SEL_W'(i);
        end
    end

    // Scan from the far end so the nearest enabled lane after lane_ptr wins;
    // k = NUM_LANES wraps onto lane_ptr itself, covering the single-enabled-lane case.
    always_comb begin
        next_en = lane_ptr;
        cand    = '0;
        for (int k = NUM_LANES; k >= 1; k--) begin
            cand = SEL_W'((int'(lane_ptr) + k) % NUM_LANES);
            if (lane_en[cand]) next_en = cand;
        end
    end

    always_comb begin
        ptr_d = lane_ptr;
        if (realign)
            ptr_d = first_en;
        else if (skip || accept)
            ptr_d = next_en;
    end

    always_ff @(posedge clk_2f) begin
        if (reset)
            lane_ptr <= '0;
        else
            lane_ptr <= ptr_d;
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        assign load[g] = accept & (lane_ptr == SEL_W'(g));

        demux_lane_reg #(.DATA_W(DATA_W)) u_lane (
            .clk_2f (clk_2f),
            .reset  (reset),
            .load   (load[g]),
            .din    (data_in),
            .ready  (lane_ready[g]),
            .dout   (lane_q[g]),
            .vld    (valid_out[g])
        );
    end

    assign data_out = lane_q;

endmodule

// File: tb/tb_demux_striping_lanes.sv
// Bench for demux_striping_lanes: directed scenarios pinned by literal expectations,
// then randomized traffic checked every cycle against a behavioural lane model.

module tb_demux_striping_lanes;
    localparam int DATA_W    = 32;
    localparam int NUM_LANES = 4;
    localparam int SEL_W     = 2;

    logic                        clk_2f = 1'b0;
    logic                        reset = 1'b0;
    logic [DATA_W-1:0]           data_in = '0;
    logic                        valid_in = 1'b0;
    logic                        in_ready;
    logic [NUM_LANES-1:0]        lane_en = '1;
    logic                        realign = 1'b0;
    logic [NUM_LANES*DATA_W-1:0] data_out;
    logic [NUM_LANES-1:0]        valid_out;
    logic [NUM_LANES-1:0]        lane_ready = '1;
    logic [SEL_W-1:0]            lane_ptr;
    logic                        err_no_lane;

    demux_striping_lanes #(.DATA_W(DATA_W), .NUM_LANES(NUM_LANES)) dut (
        .clk_2f      (clk_2f),
        .reset       (reset),
        .data_in     (data_in),
        .valid_in    (valid_in),
        .in_ready    (in_ready),
        .lane_en     (lane_en),
        .realign     (realign),
        .data_out    (data_out),
        .valid_out   (valid_out),
        .lane_ready  (lane_ready),
        .lane_ptr    (lane_ptr),
        .err_no_lane (err_no_lane)
    );

    always #5 clk_2f = ~clk_2f;

    int checks = 0;
    int errors = 0;

    // Behavioural state: what each lane holds, whether it is occupied, where the next word goes.
    logic [DATA_W-1:0] m_data [NUM_LANES];
    bit                m_vld  [NUM_LANES];
    int                m_ptr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] lane(input int i);
        return data_out[i*DATA_W +: DATA_W];
    endfunction

    function automatic int next_enabled(input int p, input logic [NUM_LANES-1:0] en);
        for (int k = 1; k <= NUM_LANES; k++)
            if (en[(p + k) % NUM_LANES]) return (p + k) % NUM_LANES;
        return p;
    endfunction

    function automatic int lowest_enabled(input logic [NUM_LANES-1:0] en);
        for (int i = 0; i < NUM_LANES; i++)
            if (en[i]) return i;
        return 0;
    endfunction

    // Apply one cycle of inputs, check combinational outputs, advance model, check registers.
    task automatic step(input logic v, input logic [31:0] d, input logic [3:0] en,
                        input logic [3:0] rdy, input logic ra, input logic rst);
        bit exp_rdy, acc;
        valid_in = v; data_in = d; lane_en = en; lane_ready = rdy; realign = ra; reset = rst;
        #1;
        exp_rdy = !ra && en[m_ptr] && (!m_vld[m_ptr] || rdy[m_ptr]);
        check("in_ready", {31'b0, in_ready}, {31'b0, exp_rdy});
        check("err_no_lane", {31'b0, err_no_lane}, {31'b0, en == 4'b0});
        acc = v && exp_rdy;
        if (rst) begin
            for (int i = 0; i < NUM_LANES; i++) begin m_data[i] = '0; m_vld[i] = 0; end
            m_ptr = 0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) if (m_vld[i] && rdy[i]) m_vld[i] = 0;
            if (acc) begin m_data[m_ptr] = d; m_vld[m_ptr] = 1; end
            if (ra) m_ptr = lowest_enabled(en);
            else if (en != 0 && (!en[m_ptr] || acc)) m_ptr = next_enabled(m_ptr, en);
        end
        @(posedge clk_2f);
        #1;
        check("lane_ptr", {30'b0, lane_ptr}, m_ptr);
        for (int i = 0; i < NUM_LANES; i++) begin
            check($sformatf("valid_out[%0d]", i), {31'b0, valid_out[i]}, {31'b0, m_vld[i]});
            check($sformatf("data_out[%0d]", i), lane(i), m_data[i]);
        end
    endtask

    initial begin
        reset = 1'b1;
        @(posedge clk_2f);
        #1;
        for (int i = 0; i < NUM_LANES; i++) begin m_data[i] = '0; m_vld[i] = 0; end
        m_ptr = 0;
        check("rst valid_out", {28'b0, valid_out}, 32'h0);
        check("rst data_out lo", data_out[63:0] == 64'b0, 32'h1);
        check("rst data_out hi", data_out[127:64] == 64'b0, 32'h1);
        check("rst lane_ptr", {30'b0, lane_ptr}, 32'h0);
        reset = 1'b0;

        // T1: full-rate striping over four lanes
        for (int i = 0; i < 8; i++) begin
            step(1, 32'hA0 + i, 4'hF, 4'hF, 0, 0);
            check("T1 ptr", {30'b0, lane_ptr}, (i + 1) % 4);
            check("T1 vld", {31'b0, valid_out[i%4]}, 32'h1);
            check("T1 data", lane(i % 4), 32'hA0 + i);
        end

        // T2: idle gaps leave the pointer alone
        step(1, 32'h10, 4'hF, 4'hF, 0, 0); check("T2 w0", lane(0), 32'h10); check("T2 p0", {30'b0, lane_ptr}, 1);
        step(0, 32'h0,  4'hF, 4'hF, 0, 0); check("T2 idle0", {30'b0, lane_ptr}, 1);
        step(1, 32'h11, 4'hF, 4'hF, 0, 0); check("T2 w1", lane(1), 32'h11); check("T2 p1", {30'b0, lane_ptr}, 2);
        step(0, 32'h0,  4'hF, 4'hF, 0, 0); check("T2 idle1", {30'b0, lane_ptr}, 2);
        step(1, 32'h12, 4'hF, 4'hF, 0, 0); check("T2 w2", lane(2), 32'h12); check("T2 p2", {30'b0, lane_ptr}, 3);

        // T3: lane 1 full and stalled blocks the input until it drains
        step(1, 32'hB0, 4'hF, 4'b1101, 0, 0);
        step(1, 32'hB1, 4'hF, 4'b1101, 0, 0);
        step(1, 32'hB2, 4'hF, 4'b1101, 0, 0);
        step(1, 32'hB3, 4'hF, 4'b1101, 0, 0);
        step(1, 32'hB4, 4'hF, 4'b1101, 0, 0);
        step(1, 32'hB8, 4'hF, 4'b1101, 0, 0);
        check("T3 ptr at 1", {30'b0, lane_ptr}, 1);
        for (int r = 0; r < 2; r++) begin
            step(1, 32'hB5, 4'hF, 4'b1101, 0, 0);
            check("T3 stall rdy", {31'b0, in_ready}, 32'h0);
            check("T3 stall ptr", {30'b0, lane_ptr}, 1);
            check("T3 lane1 held", lane(1), 32'hB2);
        end
        step(1, 32'hB5, 4'hF, 4'hF, 0, 0);
        check("T3 B5 lane1", lane(1), 32'hB5);
        check("T3 B5 vld", {31'b0, valid_out[1]}, 32'h1);
        check("T3 ptr 2", {30'b0, lane_ptr}, 2);

        // T4: sparse mask, then no lane at all
        step(0, 32'h0, 4'b1010, 4'hF, 1, 0);
        check("T4 realign", {30'b0, lane_ptr}, 1);
        for (int i = 0; i < 4; i++) begin
            step(1, 32'hC0 + i, 4'b1010, 4'hF, 0, 0);
            check("T4 data", lane((i % 2) ? 3 : 1), 32'hC0 + i);
        end
        for (int r = 0; r < 2; r++) begin
            step(1, 32'hC4, 4'b0000, 4'hF, 0, 0);
            check("T4 err", {31'b0, err_no_lane}, 32'h1);
            check("T4 rdy", {31'b0, in_ready}, 32'h0);
            check("T4 ptr hold", {30'b0, lane_ptr}, 1);
        end

        // T5: realign from lane 2
        step(1, 32'hCC, 4'hF, 4'hF, 0, 0);
        check("T5 ptr 2", {30'b0, lane_ptr}, 2);
        step(1, 32'hEE, 4'hF, 4'hF, 1, 0);
        check("T5 rdy", {31'b0, in_ready}, 32'h0);
        check("T5 ptr 0", {30'b0, lane_ptr}, 0);
        check("T5 nothing loaded", {28'b0, valid_out}, 32'h0);
        step(1, 32'hD0, 4'hF, 4'hF, 0, 0);
        check("T5 D0", lane(0), 32'hD0);

        // T6: reset mid-stream with lanes 1 and 3 occupied
        step(1, 32'hE1, 4'hF, 4'b0101, 0, 0);
        step(1, 32'hE2, 4'hF, 4'b0101, 0, 0);
        step(1, 32'hE3, 4'hF, 4'b0101, 0, 0);
        check("T6 full", {28'b0, valid_out}, 32'hA);
        step(1, 32'hF9, 4'hF, 4'b0101, 0, 1);
        check("T6 vld", {28'b0, valid_out}, 32'h0);
        check("T6 data", data_out == '0, 32'h1);
        check("T6 ptr", {30'b0, lane_ptr}, 0);
        step(1, 32'hF0, 4'hF, 4'hF, 0, 0);
        check("T6 F0", lane(0), 32'hF0);
        check("T6 F0 vld", {28'b0, valid_out}, 32'h1);

        // Randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [3:0] en;
            en = ($urandom_range(0, 5) == 0) ? 4'($urandom) : 4'hF;
            step($urandom_range(0, 3) != 0, $urandom, en, 4'($urandom),
                 $urandom_range(0, 19) == 0, $urandom_range(0, 299) == 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
